// File: rtl/adpcm_main_sdiv_32s_16s_32_seq.sv
`default_nettype none
// ============================================================================
//  Module   : adpcm_main_sdiv_32s_16s_32_seq
//  Purpose  : Multi-cycle signed divider for the ADPCM main datapath.
//             Radix-2 restoring division on operand magnitudes, followed by a
//             sign fix-up. It produces a truncate-toward-zero quotient and a
//             remainder that carries the sign of the dividend.
//  Ports    : clk        rising-edge clock
//             reset      asynchronous active-high reset
//             ce         clock enable; when low, every register holds
//             start      request, taken only while ready and ce are high
//             dividend0  signed dividend (din0_WIDTH), captured with start
//             divisor0   signed divisor (din1_WIDTH), captured with start
//             ready      high while idle
//             done       one-ce-cycle pulse marking new quot/remd
//             quot       signed quotient (dout_WIDTH), held until next done
//             remd       signed remainder (din1_WIDTH), held until next done
//  Revision : 1.0  initial release
// ============================================================================
module adpcm_main_sdiv_32s_16s_32_seq #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 34,
  parameter int din0_WIDTH = 32,
  parameter int din1_WIDTH = 16,
  parameter int dout_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] dividend0,
  input  logic [din1_WIDTH-1:0] divisor0,
  output logic                  ready,
  output logic                  done,
  output logic [dout_WIDTH-1:0] quot,
  output logic [din1_WIDTH-1:0] remd
);

  // Latency and width relations are fixed by the algorithm; refuse to
  // elaborate an inconsistent configuration.
  generate
    if ((NUM_STAGE != din0_WIDTH + 2) || (dout_WIDTH != din0_WIDTH) || (ID < 0)) begin : g_bad_cfg
      $error("adpcm_main_sdiv_32s_16s_32_seq: inconsistent parameters");
    end
  endgenerate

  localparam int CNT_W = (din0_WIDTH > 2) ? $clog2(din0_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(din0_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CNT_W-1:0]      cnt;
  logic [din0_WIDTH-1:0] q;         // dividend magnitude shifting out, quotient shifting in
  logic [din1_WIDTH-1:0] rem;       // partial remainder, always below |divisor|
  logic [din1_WIDTH-1:0] dsr_mag;
  logic [din1_WIDTH-1:0] dvd_low;   // raw low dividend bits for the divide-by-zero result
  logic                  dvd_neg;
  logic                  dsr_neg;
  logic                  dsr_zero;

  // --------------------------------------------------------------------------
  // Operand magnitudes. Unsigned, so |most-negative| is representable.
  // --------------------------------------------------------------------------
  logic [din0_WIDTH-1:0] dvd_abs;
  logic [din1_WIDTH-1:0] dsr_abs;

  always_comb begin
    dvd_abs = dividend0[din0_WIDTH-1] ? (~dividend0) + din0_WIDTH'(1) : dividend0;
    dsr_abs = divisor0[din1_WIDTH-1]  ? (~divisor0)  + din1_WIDTH'(1) : divisor0;
  end

  // --------------------------------------------------------------------------
  // One restoring step. The working remainder is din1_WIDTH+1 bits wide;
  // diff carries one extra bit whose top bit is the borrow.
  // --------------------------------------------------------------------------
  logic [din1_WIDTH:0]   sh;
  logic [din1_WIDTH+1:0] diff;
  logic                  ge;
  logic [din1_WIDTH-1:0] rem_nxt;
  logic [din0_WIDTH-1:0] q_nxt;

  always_comb begin
    sh   = {rem, q[din0_WIDTH-1]};
    diff = {1'b0, sh} - {2'b00, dsr_mag};
    // Without a borrow the difference is below |divisor|, so diff[din1_WIDTH]
    // is zero as well; testing both bits keeps the comparison self-evident.
    ge      = ~(diff[din1_WIDTH+1] | diff[din1_WIDTH]);
    rem_nxt = ge ? diff[din1_WIDTH-1:0] : sh[din1_WIDTH-1:0];
    q_nxt   = {q[din0_WIDTH-2:0], ge};
  end

  // --------------------------------------------------------------------------
  // Sign fix-up of the final magnitudes.
  // --------------------------------------------------------------------------
  logic [din0_WIDTH-1:0] quot_fix;
  logic [din1_WIDTH-1:0] remd_fix;

  always_comb begin
    if (dsr_zero) begin
      quot_fix = '1;
      remd_fix = dvd_low;
    end else begin
      quot_fix = (dvd_neg ^ dsr_neg) ? (~q) + din0_WIDTH'(1) : q;
      remd_fix = dvd_neg ? (~rem) + din1_WIDTH'(1) : rem;
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else if (ce) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = (state == IDLE);
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == CNT_LAST) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      q        <= '0;
      rem      <= '0;
      dsr_mag  <= '0;
      dvd_low  <= '0;
      dvd_neg  <= 1'b0;
      dsr_neg  <= 1'b0;
      dsr_zero <= 1'b0;
      done     <= 1'b0;
      quot     <= '0;
      remd     <= '0;
    end else if (ce) begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            q        <= dvd_abs;
            dsr_mag  <= dsr_abs;
            dvd_low  <= dividend0[din1_WIDTH-1:0];
            dvd_neg  <= dividend0[din0_WIDTH-1];
            dsr_neg  <= divisor0[din1_WIDTH-1];
            dsr_zero <= (divisor0 == '0);
            rem      <= '0;
            cnt      <= '0;
          end
        end
        RUN: begin
          rem <= rem_nxt;
          q   <= q_nxt;
          cnt <= cnt + CNT_W'(1);
        end
        FIX: begin
          quot <= quot_fix;
          remd <= remd_fix;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adpcm_main_sdiv_32s_16s_32_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adpcm_main_sdiv_32s_16s_32_seq
//  Purpose  : Self-checking bench for the multi-cycle signed divider. A
//             latency/quotient model runs alongside the DUT and is compared
//             every cycle; directed operations also check literal results.
//  Revision : 1.0  initial release
// ============================================================================
module tb_adpcm_main_sdiv_32s_16s_32_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dividend0 = '0;
  logic [15:0] divisor0 = '0;
  logic        ready;
  logic        done;
  logic [31:0] quot;
  logic [15:0] remd;

  int checks = 0;
  int errors = 0;

  adpcm_main_sdiv_32s_16s_32_seq #(
    .ID(1), .NUM_STAGE(34), .din0_WIDTH(32), .din1_WIDTH(16), .dout_WIDTH(32)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce), .start(start),
    .dividend0(dividend0), .divisor0(divisor0),
    .ready(ready), .done(done), .quot(quot), .remd(remd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: C-style division plus a busy/latency counter.
  // --------------------------------------------------------------------------
  function automatic void ref_div(input logic [31:0] a, input logic [15:0] b,
                                  output logic [31:0] qq, output logic [15:0] rr);
    longint sa, sb, lq, lr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) begin
      qq = '1;
      rr = a[15:0];
    end else begin
      lq = sa / sb;
      lr = sa % sb;
      qq = lq[31:0];
      rr = lr[15:0];
    end
  endfunction

  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  int          m_left = 0;
  logic [31:0] m_quot = '0, p_quot = '0;
  logic [15:0] m_remd = '0, p_remd = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 1'b0; m_done = 1'b0; m_left = 0; m_quot = '0; m_remd = '0;
    end else if (ce) begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_quot = p_quot;
          m_remd = p_remd;
        end
      end else if (start) begin
        m_busy = 1'b1;
        m_left = 33;
        ref_div(dividend0, divisor0, p_quot, p_remd);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("ready", {31'b0, ready}, {31'b0, !m_busy});
      chk("done",  {31'b0, done},  {31'b0, m_done});
      chk("quot",  quot, m_quot);
      chk("remd",  {16'b0, remd}, {16'b0, m_remd});
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  int lat = 0;
  int lowc = 0;
  bit ce_rand = 1'b0;

  task automatic tickc();
    if (!ce) lowc++;
    @(posedge clk);
    #2;
    lat++;
    if (ce_rand) ce = 1'($urandom_range(0, 1));
  endtask

  task automatic launch(input logic [31:0] a, input logic [15:0] b);
    ce = 1'b1;
    start = 1'b1;
    dividend0 = a;
    divisor0 = b;
    lat = 0;
    lowc = 0;
    tickc();
    start = 1'b0;
    dividend0 = $urandom;
    divisor0 = 16'($urandom);
  endtask

  task automatic wait_done(input string nm, input logic [31:0] eq, input logic [15:0] er);
    while (!done && lat < 300) tickc();
    chk({nm, " latency"}, lat, 34 + lowc);
    chk({nm, " quot"}, quot, eq);
    chk({nm, " remd"}, {16'b0, remd}, {16'b0, er});
  endtask

  // Directed table: dividend, divisor, hand-computed quotient and remainder.
  localparam int N = 8;
  logic [31:0] t_a [N] = '{32'd100, -32'sd100, 32'd100, -32'sd100,
                           32'h8000_0000, 32'h7FFF_FFFF, 32'd12345, -32'sd5};
  logic [15:0] t_b [N] = '{16'd7, 16'd7, -16'sd7, -16'sd7,
                           16'hFFFF, 16'h8000, 16'd0, 16'd0};
  logic [31:0] t_q [N] = '{32'd14, 32'hFFFF_FFF2, 32'hFFFF_FFF2, 32'd14,
                           32'h8000_0000, 32'hFFFF_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [15:0] t_r [N] = '{16'd2, 16'hFFFE, 16'd2, 16'hFFFE,
                           16'd0, 16'h7FFF, 16'h3039, 16'hFFFB};

  initial begin
    bit saw;
    // Reset state
    repeat (3) tickc();
    chk("reset ready", {31'b0, ready}, 32'd1);
    chk("reset done",  {31'b0, done},  32'd0);
    chk("reset quot",  quot, 32'd0);
    chk("reset remd",  {16'b0, remd}, 32'd0);
    reset = 1'b0;
    tickc();

    // Abort at RUN iteration 10
    launch(32'd100, 16'd7);
    repeat (10) tickc();
    chk("busy before abort", {31'b0, ready}, 32'd0);
    reset = 1'b1;
    #1;
    chk("abort ready", {31'b0, ready}, 32'd1);
    tickc();
    reset = 1'b0;
    saw = 1'b0;
    repeat (40) begin
      tickc();
      if (done) saw = 1'b1;
    end
    chk("abort no done", {31'b0, saw}, 32'd0);
    chk("abort quot", quot, 32'd0);
    chk("abort remd", {16'b0, remd}, 32'd0);

    // Directed operations; each next one starts in the done cycle.
    for (int i = 0; i < N; i++) begin
      launch(t_a[i], t_b[i]);
      wait_done($sformatf("op%0d", i), t_q[i], t_r[i]);
    end

    // Start pulsed mid-RUN is ignored.
    launch(32'd1000, 16'd10);
    repeat (10) tickc();
    start = 1'b1; dividend0 = 32'd5; divisor0 = 16'd1;
    tickc();
    start = 1'b0;
    wait_done("ignored start", 32'd100, 16'd0);

    // Pseudo-random ce during 1,000,000 / 3.
    ce_rand = 1'b1;
    launch(32'd1000000, 16'd3);
    wait_done("ce random", 32'd333333, 16'd1);
    ce_rand = 1'b0;
    ce = 1'b0;
    repeat (3) begin
      tickc();
      chk("done held", {31'b0, done}, 32'd1);
    end
    ce = 1'b1;
    tickc();
    chk("done cleared", {31'b0, done}, 32'd0);

    repeat (5) tickc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
